// File: rtl/miner_axis_ctrl_if.sv
// AXI-Stream channel bundle (32-bit data, tlast) used for the miner controller's job and
// response streams.
interface miner_axis_ctrl_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/miner_axis_ctrl.sv
// Loads a 20-word header job from AXIS, runs the miner, and returns a status/nonce response.
// Optional MINER_CTRL_STATS_EN adds a job counter and a third response word.
module miner_axis_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    miner_axis_ctrl_if.slave        s_axis,
    miner_axis_ctrl_if.master       m_axis,
    output logic [31:0]             blk_version,
    output logic [255:0]            prev_blk_header_hash,
    output logic [255:0]            merkle_root_hash,
    output logic [31:0]             blk_time,
    output logic [31:0]             blk_nbits,
    output logic [31:0]             blk_nonce,
    output logic                    miner_start,
    input  logic                    miner_done,
    input  logic                    miner_found,
    input  logic [31:0]             miner_nonce
);

    typedef enum logic [2:0] {
        StLoad, StRun, StBusy, StResp0, StResp1, StResp2, StDrain
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             found_q, found_d;
    logic [31:0]      nonce_q, nonce_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             load_beat;
    logic [2:0]       hash_sel;

`ifdef MINER_CTRL_STATS_EN
    logic [CNT_W-1:0] job_cnt_q;
    logic [CNT_W-1:0] job_snap_q;
`endif

    // Words 1..8 and 9..16 both map to (8 - idx) mod 8, i.e. word1/word9 land in the top slot.
    assign hash_sel = 3'(5'd8 - idx_q);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = err_q;
        timeout_d     = timeout_q;
        found_d       = found_q;
        nonce_d       = nonce_q;
        tcnt_d        = tcnt_q;
        load_beat     = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 32'h0;
        m_axis.tlast  = 1'b0;

        case (state_q)
            StLoad: begin
                s_axis.tready = 1'b1;
                if (s_axis.tvalid) begin
                    load_beat = 1'b1;
                    idx_d     = idx_q + 5'd1;
                    if (idx_q == 5'd19) begin
                        if (s_axis.tlast) begin
                            state_d = StRun;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (s_axis.tlast) begin
                        err_d   = 1'b1;
                        state_d = StResp0;
                    end
                end
            end
            StDrain: begin
                s_axis.tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d = StResp0;
                end
            end
            StRun: begin
                tcnt_d  = '0;
                state_d = StBusy;
            end
            StBusy: begin
                tcnt_d = tcnt_q + 1'b1;
                // Done takes priority over a timeout landing on the same cycle.
                if (miner_done) begin
                    found_d = miner_found;
                    nonce_d = miner_nonce;
                    state_d = StResp0;
                end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TimeoutLast) begin
                    timeout_d = 1'b1;
                    state_d   = StResp0;
                end
            end
            StResp0: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = {29'b0, err_q, timeout_q, found_q};
                if (m_axis.tready) begin
                    state_d = StResp1;
                end
            end
            StResp1: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = (err_q || timeout_q) ? 32'h0 : nonce_q;
`ifdef MINER_CTRL_STATS_EN
                m_axis.tlast  = 1'b0;
                if (m_axis.tready) begin
                    state_d = StResp2;
                end
`else
                m_axis.tlast  = 1'b1;
                if (m_axis.tready) begin
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    found_d   = 1'b0;
                    nonce_d   = 32'h0;
                    idx_d     = 5'd0;
                    state_d   = StLoad;
                end
`endif
            end
`ifdef MINER_CTRL_STATS_EN
            StResp2: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = 32'(job_snap_q);
                m_axis.tlast  = 1'b1;
                if (m_axis.tready) begin
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    found_d   = 1'b0;
                    nonce_d   = 32'h0;
                    idx_d     = 5'd0;
                    state_d   = StLoad;
                end
            end
`endif
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StLoad;
            idx_q       <= 5'd0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            found_q     <= 1'b0;
            nonce_q     <= 32'h0;
            tcnt_q      <= '0;
            miner_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            found_q     <= found_d;
            nonce_q     <= nonce_d;
            tcnt_q      <= tcnt_d;
            miner_start <= (state_d == StRun) || (state_d == StBusy);
        end
    end

    // Header fields change only on accepted job beats, so they stay stable through the run.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            blk_version          <= 32'h0;
            prev_blk_header_hash <= 256'h0;
            merkle_root_hash     <= 256'h0;
            blk_time             <= 32'h0;
            blk_nbits            <= 32'h0;
            blk_nonce            <= 32'h0;
        end else if (load_beat) begin
            if (idx_q == 5'd0) begin
                blk_version <= s_axis.tdata;
            end else if (idx_q <= 5'd8) begin
                prev_blk_header_hash[{hash_sel, 5'b0} +: 32] <= s_axis.tdata;
            end else if (idx_q <= 5'd16) begin
                merkle_root_hash[{hash_sel, 5'b0} +: 32] <= s_axis.tdata;
            end else if (idx_q == 5'd17) begin
                blk_time <= s_axis.tdata;
            end else if (idx_q == 5'd18) begin
                blk_nbits <= s_axis.tdata;
            end else begin
                blk_nonce <= s_axis.tdata;
            end
        end
    end

`ifdef MINER_CTRL_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            job_cnt_q  <= '0;
            job_snap_q <= '0;
        end else begin
            if (state_q == StRun) begin
                job_cnt_q <= job_cnt_q + 1'b1;
            end
            if (state_d == StResp0 && state_q != StResp0) begin
                job_snap_q <= job_cnt_q;
            end
        end
    end
`endif

endmodule

// File: doc/miner_axis_ctrl.md
Name: miner_axis_ctrl

Overview:
Sequences the bitcoin miner core from AXI-Stream. It collects one 20-word block-header job from a slave AXIS port and loads the miner's header fields. It then runs the miner and waits for done or timeout, and returns a status/nonce response on a master AXIS port. It sits between the stream VIPs/DMA and the miner inside the test IP.

Parameters:
TIMEOUT_CYCLES, 0, cycles in BUSY before abort; 0 disables the timeout
CNT_W, 32, width of the timeout counter and the job counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_axis_tdata  in  32  job word
s_axis_tvalid  in  1  job word valid
s_axis_tready  out  1  ready for job word
s_axis_tlast  in  1  last job word
m_axis_tdata  out  32  response word
m_axis_tvalid  out  1  response valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last response word
blk_version  out  32  to miner
prev_blk_header_hash  out  256  to miner
merkle_root_hash  out  256  to miner
blk_time  out  32  to miner
blk_nbits  out  32  to miner
blk_nonce  out  32  starting nonce to miner
miner_start  out  1  run request, level
miner_done  in  1  miner finished, level, held until miner_start falls
miner_found  in  1  valid with miner_done; a nonce meeting the target was found
miner_nonce  in  32  valid with miner_done

Behaviour:
- Single clock aclk; asynchronous active-low reset aresetn. Reset sets all state and outputs to 0, FSM=LOAD, word index=0.
- States: LOAD, RUN, BUSY, RESP0, RESP1, DRAIN.
- LOAD:
  - s_axis_tready=1.
  - Each beat (tvalid&tready) stores tdata by index: 0=blk_version; 1-8=prev_blk_header_hash, word1 in bits[255:224] down to word8 in [31:0]; 9-16=merkle_root_hash, same ordering; 17=blk_time; 18=blk_nbits; 19=blk_nonce.
  - Index increments per beat.
- LOAD framing:
  - tlast on index<19: set err flag, go to RESP0, miner not started.
  - Index 19 with tlast: go to RUN.
  - Index 19 without tlast: set err flag, go to DRAIN.
- DRAIN: tready=1; discard beats until a beat with tlast, then RESP0.
- RUN: one cycle. Asserts miner_start (registered), clears the timeout counter, goes to BUSY. Header outputs are stable from RUN until the next LOAD beat.
- BUSY:
  - miner_start held 1; timeout counter increments each cycle.
  - miner_done=1: latch found=miner_found, nonce=miner_nonce, drop miner_start next cycle, go to RESP0.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without done: set timeout flag, drop miner_start, go to RESP0.
  - Done and timeout in the same cycle: done wins, timeout flag stays 0.
- RESP0: m_axis_tvalid=1, tdata={29'b0, err, timeout, found}, tlast=0. Advance on tready.
- RESP1:
  - tvalid=1, tdata=latched nonce (0 if err or timeout), tlast=1.
  - On tready: clear flags and index, go to LOAD.
- s_axis_tready=0 outside LOAD/DRAIN.
- m_axis_tdata/tlast hold stable while tvalid=1 and tready=0.
- miner_start is 0 in all states except RUN and BUSY.
- Latency: the last job beat to miner_start high is 1 cycle. miner_done high to m_axis_tvalid high is 1 cycle.
- aresetn low mid-job: immediate abort to reset values; any partial response is lost.

Optional Feature:
MINER_CTRL_STATS_EN
- Defined: a CNT_W job counter increments on each RUN→BUSY entry; it wraps at 2^CNT_W and is reset only by aresetn.
  - A third response word follows RESP1 (state RESP2, tdata=counter value sampled at RESP0 entry).
  - tlast moves from RESP1 to RESP2.
- Undefined: no counter, no RESP2; the response is 2 words.

Test Plan:
- Job of 20 words (version 0x20000000, nonce 0x00000010), miner model returns done+found with nonce 0x0000002A after 50 cycles -> miner_start high 1 cycle after the last beat. Response is 0x00000001 then 0x0000002A with tlast on word 2. Header outputs match the words in order, word1 at prev_blk_header_hash[255:224].
- tlast on word 5 -> miner_start never asserts; response 0x00000004, 0x00000000; the next full job then runs normally.
- 23-word job without tlast at word 19 -> words 20-22 drained; response 0x00000004, 0x00000000.
- TIMEOUT_CYCLES=100, miner never signals done -> miner_start falls after 100 BUSY cycles; response 0x00000002, 0x00000000.
- m_axis_tready held 0 for 10 cycles during RESP0/RESP1 -> tdata/tlast stable, s_axis_tready=0 throughout. aresetn pulsed low in BUSY -> miner_start=0 and m_axis_tvalid=0 immediately.
- MINER_CTRL_STATS_EN defined, 3 back-to-back jobs -> third response words are 1, 2, 3, with tlast only on them.
